led_shift_ctrl: RTL and testbench

Consumes the divided clock produced by the frequency-divider stage and drives a one-hot LED pattern. The block runs entirely in the fast `clk` domain: it edge-detects the slow divided clock into single-cycle step strobes, then advances a rotate or bounce pattern on each strobe. It sits directly downstream of the divider and feeds the board LEDs.

---
 rtl/led_shift_ctrl_if.sv | 25 ++
 rtl/led_shift_ctrl.sv | 119 +++++++++++
 tb/tb_led_shift_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/led_shift_ctrl_if.sv
// Signal bundle between the divider-side controller and led_shift_ctrl.
// master drives the divided clock, enable and mode; slave returns the LED pattern.
interface led_shift_ctrl_if #(
    parameter int unsigned POS_W = 3
);
    localparam int unsigned W = 2 ** POS_W;

    logic             clk_div;
    logic             en;
    logic [1:0]       mode;
    logic [W-1:0]     led;
    logic [POS_W-1:0] pos;
    logic             dir;
    logic             tick;

    modport master (
        output clk_div, en, mode,
        input  led, pos, dir, tick
    );

    modport slave (
        input  clk_div, en, mode,
        output led, pos, dir, tick
    );
endinterface

// File: rtl/led_shift_ctrl.sv
// One-hot LED rotate/bounce driver stepped by rising edges of a divided clock.
// Define LED_SHIFT_SYNC_EN to add a two-flop synchronizer on clk_div (cross-domain use).
module led_shift_ctrl #(
    parameter int unsigned POS_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    led_shift_ctrl_if.slave   bus
);
    localparam int unsigned W = 2 ** POS_W;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    logic [W-1:0]     r_led;
    logic [POS_W-1:0] r_pos;
    dir_t             r_dir;
    logic             r_tick;
    logic             r_clk_div_d;
    logic             r_armed;

    logic [W-1:0]     w_led_nxt;
    logic [POS_W-1:0] w_pos_nxt;
    dir_t             w_dir_nxt;
    logic             w_clk_div_s;
    logic             w_step;
    logic             w_onehot;

`ifdef LED_SHIFT_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.clk_div;
            r_sync2 <= r_sync1;
        end
    end

    assign w_clk_div_s = r_sync2;
`else
    assign w_clk_div_s = bus.clk_div;
`endif

    // r_armed keeps a clk_div level that is already high at reset release from counting as a rise
    assign w_step   = w_clk_div_s & ~r_clk_div_d & r_armed & bus.en;
    assign w_onehot = (r_led != '0) && ((r_led & (r_led - W'(1))) == '0);

    always_comb begin
        w_led_nxt = r_led;
        w_dir_nxt = r_dir;
        if (w_step) begin
            if (!w_onehot) begin
                w_led_nxt = W'(1);
                w_dir_nxt = DIR_UP;
            end else begin
                case (bus.mode)
                    2'b00: w_led_nxt = {r_led[W-2:0], r_led[W-1]};
                    2'b01: w_led_nxt = {r_led[0], r_led[W-1:1]};
                    2'b10: begin
                        if (r_dir == DIR_UP) begin
                            if (r_led[W-1]) begin
                                w_dir_nxt = DIR_DN;
                                w_led_nxt = r_led >> 1;
                            end else begin
                                w_led_nxt = r_led << 1;
                            end
                        end else begin
                            if (r_led[0]) begin
                                w_dir_nxt = DIR_UP;
                                w_led_nxt = r_led << 1;
                            end else begin
                                w_led_nxt = r_led >> 1;
                            end
                        end
                    end
                    default: w_led_nxt = r_led;
                endcase
            end
        end
    end

    always_comb begin
        w_pos_nxt = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (w_led_nxt[i]) begin
                w_pos_nxt = POS_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led       <= W'(1);
            r_pos       <= '0;
            r_dir       <= DIR_UP;
            r_tick      <= 1'b0;
            r_clk_div_d <= 1'b0;
            r_armed     <= ~w_clk_div_s;
        end else begin
            r_led       <= w_led_nxt;
            r_pos       <= w_pos_nxt;
            r_dir       <= w_dir_nxt;
            r_tick      <= w_step;
            r_clk_div_d <= w_clk_div_s;
            r_armed     <= r_armed | ~w_clk_div_s;
        end
    end

    assign bus.led  = r_led;
    assign bus.pos  = r_pos;
    assign bus.dir  = r_dir;
    assign bus.tick = r_tick;
endmodule

// File: tb/tb_led_shift_ctrl.sv
// Self-checking bench for led_shift_ctrl: directed scenarios plus random traffic,
// every cycle compared against an index-based behavioural model.
module tb_led_shift_ctrl;
    localparam int unsigned POS_W = 3;
    localparam int unsigned W     = 8;
`ifdef LED_SHIFT_SYNC_EN
    localparam int LAT     = 2;
    localparam int REL_EXP = 1;
`else
    localparam int LAT     = 0;
    localparam int REL_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_shift_ctrl_if #(.POS_W(POS_W)) bus ();

    led_shift_ctrl #(.POS_W(POS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: position index, bounce direction, last seen clk_div level.
    int m_p    = 0;
    int m_dir  = 0;
    int m_tick = 0;
    int m_prev = 0;
    int m_s1   = 0;
    int m_s2   = 0;
    int tick_cnt = 0;

    logic [7:0] rol_exp [9];
    logic [7:0] ref_led;
    int lat;
    int t0;
    logic cd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic e, input logic [1:0] m, input logic r);
        int eff;
        bit st;
        rst         = r;
        bus.clk_div = c;
        bus.en      = e;
        bus.mode    = m;
        @(posedge clk);
        #1;
`ifdef LED_SHIFT_SYNC_EN
        eff  = m_s2;
        m_s2 = r ? 0 : m_s1;
        m_s1 = r ? 0 : int'(c);
`else
        eff = int'(c);
`endif
        if (r) begin
            m_p    = 0;
            m_dir  = 0;
            m_tick = 0;
        end else begin
            st     = (eff == 1) && (m_prev == 0) && (e === 1'b1);
            m_tick = st ? 1 : 0;
            if (st) begin
                case (m)
                    2'd0: m_p = (m_p + 1) % W;
                    2'd1: m_p = (m_p + W - 1) % W;
                    2'd2: begin
                        if (m_dir == 0) begin
                            if (m_p == W - 1) begin m_dir = 1; m_p--; end
                            else m_p++;
                        end else begin
                            if (m_p == 0) begin m_dir = 0; m_p++; end
                            else m_p--;
                        end
                    end
                    default: ;
                endcase
            end
        end
        m_prev = eff;
        if (bus.tick === 1'b1) tick_cnt++;
        chk("led",  32'(bus.led),  32'(1) << m_p);
        chk("pos",  32'(bus.pos),  32'(m_p));
        chk("dir",  32'(bus.dir),  32'(m_dir));
        chk("tick", 32'(bus.tick), 32'(m_tick));
    endtask

    task automatic pulse(input logic e, input logic [1:0] m);
        cyc(1'b1, e, m, 1'b0);
        repeat (3) cyc(1'b0, e, m, 1'b0);
    endtask

    task automatic do_reset();
        repeat (2) cyc(1'b0, 1'b0, 2'd0, 1'b1);
        cyc(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        rol_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
        bus.clk_div = 1'b0;
        bus.en      = 1'b0;
        bus.mode    = 2'd0;

        // Reset held while clk_div toggles.
        for (int i = 0; i < 4; i++) begin
            cd = i[0];
            cyc(cd, 1'b1, 2'd0, 1'b1);
            chk("rst_led",  32'(bus.led),  32'h01);
            chk("rst_tick", 32'(bus.tick), 32'h0);
        end
        repeat (3) cyc(1'b0, 1'b1, 2'd0, 1'b0);

        // Rotate left, 9 steps, then rotate right from reset.
        tick_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            pulse(1'b1, 2'd0);
            chk("rol_led", 32'(bus.led), 32'(rol_exp[i]));
            chk("rol_pos", 32'(bus.pos), 32'((i + 1) % 8));
        end
        chk("rol_ticks", 32'(tick_cnt), 32'd9);
        do_reset();
        pulse(1'b1, 2'd1);
        chk("ror_first", 32'(bus.led), 32'h80);

        // Bounce from reset, 16 steps; MSB and LSB each shown once.
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            pulse(1'b1, 2'd2);
            if (i == 7)  begin chk("bnc7_led",  32'(bus.led), 32'h80); chk("bnc7_dir",  32'(bus.dir), 32'd0); end
            if (i == 8)  begin chk("bnc8_led",  32'(bus.led), 32'h40); chk("bnc8_dir",  32'(bus.dir), 32'd1); end
            if (i == 14) begin chk("bnc14_led", 32'(bus.led), 32'h01); chk("bnc14_dir", 32'(bus.dir), 32'd1); end
            if (i == 15) begin chk("bnc15_led", 32'(bus.led), 32'h02); chk("bnc15_dir", 32'(bus.dir), 32'd0); end
        end

        // Enable off, hold mode, and stored direction surviving a rotate.
        do_reset();
        repeat (8) pulse(1'b1, 2'd2);
        tick_cnt = 0;
        repeat (3) pulse(1'b0, 2'd2);
        chk("en0_led",   32'(bus.led), 32'h40);
        chk("en0_ticks", 32'(tick_cnt), 32'd0);
        repeat (3) pulse(1'b1, 2'd3);
        chk("hold_led",   32'(bus.led), 32'h40);
        chk("hold_ticks", 32'(tick_cnt), 32'd3);
        pulse(1'b1, 2'd0);
        chk("rot_keeps_dir", 32'(bus.dir), 32'd1);
        pulse(1'b1, 2'd2);
        chk("resume_led", 32'(bus.led), 32'h40);
        pulse(1'b1, 2'd2);
        chk("resume_led2", 32'(bus.led), 32'h20);

        // Long-high clk_div gives one step; en rising during high gives none.
        tick_cnt = 0;
        repeat (20) cyc(1'b1, 1'b1, 2'd0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 2'd0, 1'b0);
        chk("long_high_ticks", 32'(tick_cnt), 32'd1);
        tick_cnt = 0;
        repeat (3) cyc(1'b1, 1'b0, 2'd0, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 2'd0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 2'd0, 1'b0);
        chk("late_en_ticks", 32'(tick_cnt), 32'd0);

        // Reset on the edge of a qualifying rise, clk_div still high at release.
        cyc(1'b1, 1'b1, 2'd0, 1'b1);
        chk("rst_edge_led",  32'(bus.led),  32'h01);
        chk("rst_edge_tick", 32'(bus.tick), 32'h0);
        tick_cnt = 0;
        repeat (4) cyc(1'b1, 1'b1, 2'd0, 1'b0);
        chk("release_high_ticks", 32'(tick_cnt), 32'(REL_EXP));

        // Rise-to-update latency.
        repeat (4) cyc(1'b0, 1'b1, 2'd0, 1'b0);
        ref_led = bus.led;
        lat = -1;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b1, 2'd0, 1'b0);
            if (lat < 0 && bus.led !== ref_led) lat = k;
        end
        chk("latency", 32'(lat), 32'(LAT));
        repeat (3) cyc(1'b0, 1'b1, 2'd0, 1'b0);

        // Random traffic with occasional resets.
        cd = 1'b0;
        for (int i = 0; i < 600; i++) begin
            t0 = int'($urandom_range(0, 2));
            if (t0 == 0) cd = ~cd;
            cyc(cd, ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 60) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
